// File: rtl/bcd_7seg_scan.sv
// bcd_7seg_scan
// Captures the units/tens/hundreds BCD digits from the converter on a rising
// in_DONE and drives a 3-digit multiplexed common-anode 7-segment display.
// It also sends a one-cycle out_INIT request back to the converter. One
// request follows reset release. After that a request is sent every
// UPDATE_FRAMES complete scan frames.
//
// Optional build macro:
//   BCD_LZB_EN  leading-zero blanking of the hundreds and tens digits.
//
// Scan state machine (digit currently selected):
//   state        | meaning
//   DIG_UNITS    | units digit selected, anode bit0 driven low
//   DIG_TENS     | tens digit selected, anode bit1 driven low
//   DIG_HUNDREDS | hundreds digit selected, anode bit2 driven low

module bcd_7seg_scan #(
   parameter int REFRESH_DIV   = 50000,
   parameter int UPDATE_FRAMES = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] in_UND,
   input  logic [3:0] in_DEC,
   input  logic [3:0] in_CEN,
   input  logic       in_DONE,
   output logic       out_INIT,
   output logic [6:0] out_SEG,
   output logic [2:0] out_AN,
   output logic       out_VALID
);

   localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int FW = (UPDATE_FRAMES > 1) ? $clog2(UPDATE_FRAMES) : 1;
   localparam logic [PW-1:0] PRESC_TC = PW'(REFRESH_DIV - 1);
   localparam logic [FW-1:0] FRAME_TC = FW'(UPDATE_FRAMES - 1);

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_DASH  = 7'h3F;

   generate
      if (REFRESH_DIV < 2) begin : g_bad_div
         $error("bcd_7seg_scan: REFRESH_DIV must be at least 2");
      end
      if (UPDATE_FRAMES < 1) begin : g_bad_frames
         $error("bcd_7seg_scan: UPDATE_FRAMES must be at least 1");
      end
   endgenerate

   typedef enum logic [1:0] {
      DIG_UNITS    = 2'd0,
      DIG_TENS     = 2'd1,
      DIG_HUNDREDS = 2'd2
   } dig_t;

   dig_t          dig_q;
   dig_t          dig_d;

   logic [PW-1:0] presc_q;
   logic          presc_tc;
   logic [FW-1:0] frame_q;
   logic          frame_tc;
   logic          scan_wrap;

   logic          done_q;
   logic          capture;
   logic [3:0]    und_q;
   logic [3:0]    dec_q;
   logic [3:0]    cen_q;
   logic          valid_q;

   logic          boot_q;
   logic          init_q;
   logic [6:0]    seg_q;
   logic [2:0]    an_q;

   logic [2:0]    an_nxt;
   logic [3:0]    sel_code;
   logic          sel_blank;
   logic [6:0]    seg_nxt;
   logic          blank_cen;
   logic          blank_dec;

   // Active-low segment patterns {g,f,e,d,c,b,a}. Non-decimal codes show a dash.
   function automatic logic [6:0] seg_decode(input logic [3:0] code);
      logic [6:0] seg;
      case (code)
         4'd0:    seg = 7'h40;
         4'd1:    seg = 7'h79;
         4'd2:    seg = 7'h24;
         4'd3:    seg = 7'h30;
         4'd4:    seg = 7'h19;
         4'd5:    seg = 7'h12;
         4'd6:    seg = 7'h02;
         4'd7:    seg = 7'h78;
         4'd8:    seg = 7'h00;
         4'd9:    seg = 7'h10;
         default: seg = SEG_DASH;
      endcase
      return seg;
   endfunction

   assign capture   = in_DONE & ~done_q;
   assign presc_tc  = (presc_q == PRESC_TC);
   assign frame_tc  = (frame_q == FRAME_TC);
   assign scan_wrap = presc_tc && (dig_q == DIG_HUNDREDS);

`ifdef BCD_LZB_EN
   // A zero hundreds digit is a leading zero. A zero tens digit is a leading
   // zero only when hundreds is also zero. Dash codes are never zero, so a
   // dash is never blanked.
   assign blank_cen = (cen_q == 4'd0);
   assign blank_dec = (cen_q == 4'd0) && (dec_q == 4'd0);
`else
   assign blank_cen = 1'b0;
   assign blank_dec = 1'b0;
`endif

   // Detect a rising in_DONE and load the digit registers when it occurs.
   // A level that is held high does not reload the digits.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         done_q  <= 1'b0;
         und_q   <= 4'd0;
         dec_q   <= 4'd0;
         cen_q   <= 4'd0;
         valid_q <= 1'b0;
      end else begin
         done_q <= in_DONE;
         if (capture) begin
            und_q   <= in_UND;
            dec_q   <= in_DEC;
            cen_q   <= in_CEN;
            valid_q <= 1'b1;
         end
      end
   end

   // The refresh prescaler sets how long each digit stays selected.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         presc_q <= '0;
      end else if (presc_tc) begin
         presc_q <= '0;
      end else begin
         presc_q <= presc_q + PW'(1);
      end
   end

   // Scan state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dig_q <= DIG_UNITS;
      end else begin
         dig_q <= dig_d;
      end
   end

   // Next scan state, anode pattern and digit selection for the current state.
   always_comb begin
      dig_d     = dig_q;
      an_nxt    = 3'b111;
      sel_code  = und_q;
      sel_blank = 1'b0;
      case (dig_q)
         DIG_UNITS: begin
            an_nxt   = 3'b110;
            sel_code = und_q;
            if (presc_tc) dig_d = DIG_TENS;
         end
         DIG_TENS: begin
            an_nxt    = 3'b101;
            sel_code  = dec_q;
            sel_blank = blank_dec;
            if (presc_tc) dig_d = DIG_HUNDREDS;
         end
         DIG_HUNDREDS: begin
            an_nxt    = 3'b011;
            sel_code  = cen_q;
            sel_blank = blank_cen;
            if (presc_tc) dig_d = DIG_UNITS;
         end
         default: begin
            dig_d = DIG_UNITS;
         end
      endcase
   end

   // Segment pattern for the selected digit. The display stays dark until the
   // first capture.
   always_comb begin
      seg_nxt = SEG_BLANK;
      if (valid_q && !sel_blank) begin
         seg_nxt = seg_decode(sel_code);
      end
   end

   // Count complete frames. Request a conversion on the last frame wrap and
   // once right after reset release.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         frame_q <= '0;
         boot_q  <= 1'b1;
         init_q  <= 1'b0;
      end else begin
         boot_q <= 1'b0;
         init_q <= boot_q | (scan_wrap & frame_tc);
         if (scan_wrap) begin
            if (frame_tc) begin
               frame_q <= '0;
            end else begin
               frame_q <= frame_q + FW'(1);
            end
         end
      end
   end

   // Register the pin-facing segment and anode drives.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         seg_q <= SEG_BLANK;
         an_q  <= 3'b111;
      end else begin
         seg_q <= seg_nxt;
         an_q  <= an_nxt;
      end
   end

   assign out_INIT  = init_q;
   assign out_SEG   = seg_q;
   assign out_AN    = an_q;
   assign out_VALID = valid_q;

endmodule

// File: tb/tb_bcd_7seg_scan.sv
// Testbench for bcd_7seg_scan with REFRESH_DIV=4 and UPDATE_FRAMES=2.
// The reference model works from the number of edges since reset release.
// It derives the selected digit and the conversion-request times from that
// count, and it tracks the captured digits itself.
module tb_bcd_7seg_scan;
   localparam int N  = 4;
   localparam int UF = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] in_UND = 4'd0;
   logic [3:0] in_DEC = 4'd0;
   logic [3:0] in_CEN = 4'd0;
   logic       in_DONE = 1'b0;
   logic       out_INIT;
   logic [6:0] out_SEG;
   logic [2:0] out_AN;
   logic       out_VALID;

   bcd_7seg_scan #(.REFRESH_DIV(N), .UPDATE_FRAMES(UF)) dut (
      .clk(clk), .rst(rst),
      .in_UND(in_UND), .in_DEC(in_DEC), .in_CEN(in_CEN), .in_DONE(in_DONE),
      .out_INIT(out_INIT), .out_SEG(out_SEG), .out_AN(out_AN), .out_VALID(out_VALID)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model state.
   logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
   int         m_t     = 0;
   bit         m_valid = 0;
   bit         m_prev  = 0;
   logic [3:0] m_dig [3] = '{4'd0, 4'd0, 4'd0};
   logic [6:0] e_seg   = 7'h7F;
   logic [2:0] e_an    = 3'b111;
   logic       e_init  = 1'b0;
   logic       e_valid = 1'b0;

   function automatic logic [6:0] model_seg(input int idx);
      logic [3:0] code;
      code = m_dig[idx];
      if (code > 4'd9) return 7'h3F;
`ifdef BCD_LZB_EN
      if (idx == 2 && m_dig[2] == 4'd0) return 7'h7F;
      if (idx == 1 && m_dig[2] == 4'd0 && m_dig[1] == 4'd0) return 7'h7F;
`endif
      return seg_tab[code];
   endfunction

   // Compute the outputs expected after each edge from the state before it,
   // then update the model's own capture state.
   always @(posedge clk or negedge rst) begin
      int idx;
      if (!rst) begin
         m_t = 0; m_valid = 0; m_prev = 0;
         m_dig[0] = 4'd0; m_dig[1] = 4'd0; m_dig[2] = 4'd0;
         e_seg = 7'h7F; e_an = 3'b111; e_init = 1'b0; e_valid = 1'b0;
      end else begin
         idx    = (m_t / N) % 3;
         e_an   = ~(3'b001 << idx);
         e_seg  = m_valid ? model_seg(idx) : 7'h7F;
         m_t    = m_t + 1;
         e_init = (m_t == 1) || (m_t % (3 * N * UF) == 0);
         if (in_DONE && !m_prev) begin
            m_dig[0] = in_UND; m_dig[1] = in_DEC; m_dig[2] = in_CEN;
            m_valid  = 1;
         end
         m_prev  = in_DONE;
         e_valid = m_valid;
      end
   end

   // Compare every output against the model, halfway through each cycle.
   always @(negedge clk) begin
      check("model_seg",   8'(out_SEG),   8'(e_seg));
      check("model_an",    8'(out_AN),    8'(e_an));
      check("model_init",  8'(out_INIT),  8'(e_init));
      check("model_valid", 8'(out_VALID), 8'(e_valid));
   end

   task automatic wait_init(output int n);
      n = 0;
      while (out_INIT !== 1'b1 && n < 60) begin
         @(negedge clk);
         n++;
      end
      if (out_INIT !== 1'b1) check("init_timeout", 8'(out_INIT), 8'd1);
   endtask

   task automatic show_digit(input string nm, input logic [2:0] an, input logic [6:0] seg);
      int k;
      k = 0;
      while (out_AN !== an && k < 20) begin
         @(negedge clk);
         k++;
      end
      check({nm, "_an"}, 8'(out_AN), 8'(an));
      check(nm, 8'(out_SEG), 8'(seg));
   endtask

   task automatic capture(input logic [3:0] u, input logic [3:0] d, input logic [3:0] c);
      in_UND = u; in_DEC = d; in_CEN = c; in_DONE = 1'b1;
      @(negedge clk);
      in_DONE = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      int n;
      #1 rst = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_seg",   8'(out_SEG),   8'h7F);
      check("rst_an",    8'(out_AN),    8'h07);
      check("rst_init",  8'(out_INIT),  8'h00);
      check("rst_valid", 8'(out_VALID), 8'h00);

      @(negedge clk); rst = 1'b1;
      @(negedge clk);
      check("boot_init", 8'(out_INIT), 8'h01);
      check("boot_an",   8'(out_AN),   8'h06);
      check("boot_seg",  8'(out_SEG),  8'h7F);
      @(negedge clk);
      check("boot_init_width", 8'(out_INIT), 8'h00);
      repeat (3) @(negedge clk);
      check("scan_an_tens", 8'(out_AN), 8'h05);
      repeat (4) @(negedge clk);
      check("scan_an_hund", 8'(out_AN), 8'h03);

      wait_init(n);
      @(negedge clk);
      wait_init(n);
      check("init_period", 8'(n + 1), 8'd24);

      in_UND = 4'd3; in_DEC = 4'd5; in_CEN = 4'd2; in_DONE = 1'b1;
      @(negedge clk);
      in_UND = 4'd9; in_DEC = 4'd9; in_CEN = 4'd9;
      @(negedge clk);
      check("cap_valid", 8'(out_VALID), 8'h01);
      show_digit("u253", 3'b110, 7'h30);
      show_digit("t253", 3'b101, 7'h12);
      show_digit("h253", 3'b011, 7'h24);
      show_digit("u253_held", 3'b110, 7'h30);
      in_DONE = 1'b0;
      @(negedge clk);

      capture(4'd7, 4'd0, 4'd0);
      show_digit("u007", 3'b110, 7'h78);
`ifdef BCD_LZB_EN
      show_digit("t007", 3'b101, 7'h7F);
      show_digit("h007", 3'b011, 7'h7F);
`else
      show_digit("t007", 3'b101, 7'h40);
      show_digit("h007", 3'b011, 7'h40);
`endif

      capture(4'hC, 4'd1, 4'd1);
      show_digit("u_dash", 3'b110, 7'h3F);
      show_digit("t_one",  3'b101, 7'h79);

      wait_init(n);
      in_UND = 4'd8; in_DEC = 4'd6; in_CEN = 4'd1; in_DONE = 1'b1;
      @(negedge clk);
      in_DONE = 1'b0;
      @(negedge clk);
      show_digit("u_with_init", 3'b110, 7'h00);
      show_digit("t_with_init", 3'b101, 7'h02);
      show_digit("h_with_init", 3'b011, 7'h79);

      repeat (5) @(negedge clk);
      #3 rst = 1'b0;
      #1;
      check("arst_seg",   8'(out_SEG),   8'h7F);
      check("arst_an",    8'(out_AN),    8'h07);
      check("arst_init",  8'(out_INIT),  8'h00);
      check("arst_valid", 8'(out_VALID), 8'h00);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("reboot_init", 8'(out_INIT), 8'h01);
      check("reboot_seg",  8'(out_SEG),  8'h7F);
      repeat (30) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/bcd_7seg_scan.md
# bcd_7seg_scan

Downstream consumer of the BCD converter. Captures the three BCD digits (units, tens, hundreds) when the converter signals done, and drives a 3-digit multiplexed common-anode 7-segment display. Periodically issues a one-cycle `init` request back to the converter so the display tracks a changing binary input. Sits between the converter outputs and the board's segment/anode pins.

## Interface
- `REFRESH_DIV`, 50000: clock cycles each digit stays selected; must be ≥2.
- `UPDATE_FRAMES`, 16: full 3-digit scan frames between successive `out_INIT` pulses; must be ≥1.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `in_UND`  in  4  units digit from the converter.
- `in_DEC`  in  4  tens digit.
- `in_CEN`  in  4  hundreds digit.
- `in_DONE`  in  1  converter done; a rising edge qualifies the digits.
- `out_INIT`  out  1  one-cycle conversion request to the converter.
- `out_SEG`  out  7  segments {g,f,e,d,c,b,a}, active-low.
- `out_AN`  out  3  digit enables, active-low; bit0 = units, bit1 = tens, bit2 = hundreds.
- `out_VALID`  out  1  high once at least one capture has occurred since reset.

## Operation
- Edge detect: register `in_DONE`. Capture happens when `in_DONE`=1 and the previous sample was 0. On capture, load the three 4-bit digit registers and set `out_VALID`. A level held high does not re-capture.
- Prescaler: counts 0..`REFRESH_DIV`-1 and wraps. On its terminal count, the digit index advances 0→1→2→0.
- Frame counter: counts 0..`UPDATE_FRAMES`-1 and increments when the index wraps 2→0. When the frame counter is at `UPDATE_FRAMES`-1 and the index wraps, the frame counter returns to 0 and `out_INIT` pulses for one cycle.
- Boot request: a flag pulses `out_INIT` in the first clock after reset release, independent of the frame counter.
- Anode mapping: index 0 → `out_AN`=3'b110; index 1 → 3'b101; index 2 → 3'b011.
- Decode (active-low):
  - 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10.
  - Codes 10–15 → dash 7'h3F.
  - Blank → 7'h7F.
- While `out_VALID`=0, `out_SEG`=7'h7F; the anodes keep scanning.

## Timing
- Reset values: `out_SEG`=7'h7F, `out_AN`=3'b111, `out_INIT`=0, `out_VALID`=0. Prescaler, index, frame counter and digit registers are 0; the edge-detect register is 0.
- `out_SEG` and `out_AN` are registered from the index and digit registers, giving one cycle of latency. The first cycle after reset release drives `out_AN`=3'b110.
- Capture to display: digits are loaded at the edge where the rising `in_DONE` is sampled. `out_SEG` reflects the new value one edge later if that digit is selected.
- Simultaneous capture and index advance: both take effect. The newly selected digit shows the newly captured value one cycle later.
- `in_DONE` rising in the same cycle as `out_INIT`: capture proceeds normally; the two are independent.
- Reset asserted mid-scan or mid-frame clears all state immediately (asynchronous). The display blanks and `out_VALID` drops.
- Frame period = 3×`REFRESH_DIV` cycles. The `out_INIT` period is 3×`REFRESH_DIV`×`UPDATE_FRAMES` cycles.

## Configuration
- `BCD_LZB_EN` defined: leading-zero blanking.
  - Hundreds shows blank (7'h7F) when captured `in_CEN`=0.
  - Tens shows blank when `in_CEN`=0 and `in_DEC`=0.
  - Units is never blanked.
  - Dash codes are never blanked.
- `BCD_LZB_EN` undefined: all three digits are always decoded, e.g. 7 displays as "007".

## Test plan
Bench parameters: `REFRESH_DIV`=4, `UPDATE_FRAMES`=2.
- Reset then release, with no `in_DONE`: `out_INIT` is high exactly one cycle after release. `out_SEG`=7'h7F on all digits. `out_AN` cycles 110→101→011, 4 cycles each.
- Pulse `in_DONE` with digits 3/5/2 (value 253): `out_VALID`=1 and the scan shows units 7'h30, tens 7'h12, hundreds 7'h24. Holding `in_DONE` high while changing the inputs leaves the display unchanged.
- Free run: `out_INIT` pulses every 24 cycles, one cycle wide, aligned with the index 2→0 wrap.
- Capture 0/0/7 with `BCD_LZB_EN` defined: hundreds and tens are 7'h7F, units 7'h78. Without the macro: 7'h40, 7'h40, 7'h78.
- Capture units=4'hC: the units digit shows the dash 7'h3F.
- Assert `rst` mid-frame after a capture: outputs return to reset values asynchronously, `out_VALID`=0, and a new boot `out_INIT` follows release.
